// File: rtl/mips_run_monitor.sv
// Run harness for mips_16bit: sequences CPU reset, traces (pc, alu_result) on pc change,
// flags a stuck PC and counts run cycles. Define MON_BREAK_EN to enable the pc breakpoint.
module mips_run_monitor #(
    parameter int PC_W     = 16,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int RST_HOLD = 5,
    parameter int HANG_CYC = 8,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic [PC_W-1:0]          pc_in,
    input  logic [DATA_W-1:0]        result_in,
    output logic                     cpu_reset,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [PC_W-1:0]          rd_pc,
    output logic [DATA_W-1:0]        rd_result,
    output logic [$clog2(DEPTH):0]   trace_count,
    output logic                     overflow,
    output logic                     hang,
    output logic [1:0]               state,
    output logic [CNT_W-1:0]         cycle_count,
    input  logic                     bp_en,
    input  logic [PC_W-1:0]          bp_addr
);
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int SAME_W = $clog2(HANG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [SAME_W-1:0] HANG_LAST = SAME_W'(HANG_CYC - 1);
    localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10
    } state_t;

    state_t                   state_reg, state_next;
    logic [HOLD_W-1:0]        hold_cnt_reg;
    logic [SAME_W-1:0]        same_cnt_reg;
    logic [PC_W-1:0]          last_pc_reg;
    logic                     first_reg;
    logic [AW-1:0]            wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]            count_reg;
    logic [PC_W+DATA_W-1:0]   mem [DEPTH];
    logic                     rd_valid_reg, overflow_reg, hang_reg;
    logic [PC_W-1:0]          rd_pc_reg;
    logic [DATA_W-1:0]        rd_result_reg;
    logic [CNT_W-1:0]         cycle_count_reg;

    logic run, pc_same, capture, hang_hit, bp_hit;
    logic full, empty, pop, push, drop;

    assign run      = (state_reg == ST_RUN);
    // The first RUN cycle after reset/clr always counts as a pc change.
    assign pc_same  = !first_reg && (pc_in == last_pc_reg);
    assign capture  = run && !pc_same;
    assign hang_hit = run && pc_same && (same_cnt_reg == HANG_LAST);

`ifdef MON_BREAK_EN
    assign bp_hit = capture && bp_en && (pc_in == bp_addr);
`else
    logic bp_unused;
    assign bp_unused = bp_en ^ (^bp_addr);
    assign bp_hit    = 1'b0;
`endif

    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    assign pop   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push  = capture && (!full || pop);
    assign drop  = capture && full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= ST_HOLD;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = ST_HOLD;
        end else begin
            case (state_reg)
                ST_HOLD: if (hold_cnt_reg == HOLD_LAST) state_next = ST_RUN;
                ST_RUN:  if (hang_hit || bp_hit)        state_next = ST_STOP;
                ST_STOP: state_next = ST_STOP;
                default: state_next = ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr_reg] <= {pc_in, result_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_reg    <= '0;
            same_cnt_reg    <= '0;
            last_pc_reg     <= '0;
            first_reg       <= 1'b1;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            rd_valid_reg    <= 1'b0;
            rd_pc_reg       <= '0;
            rd_result_reg   <= '0;
            overflow_reg    <= 1'b0;
            hang_reg        <= 1'b0;
            cycle_count_reg <= '0;
        end else if (clr) begin
            hold_cnt_reg    <= '0;
            same_cnt_reg    <= '0;
            first_reg       <= 1'b1;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            rd_valid_reg    <= 1'b0;
            overflow_reg    <= 1'b0;
            hang_reg        <= 1'b0;
            cycle_count_reg <= '0;
        end else begin
            hold_cnt_reg <= (state_reg == ST_HOLD) ? hold_cnt_reg + 1'b1 : '0;
            rd_valid_reg <= pop;
            if (pop) begin
                {rd_pc_reg, rd_result_reg} <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop) overflow_reg <= 1'b1;
            if (run) begin
                if (cycle_count_reg != '1) cycle_count_reg <= cycle_count_reg + 1'b1;
                last_pc_reg  <= pc_in;
                first_reg    <= 1'b0;
                same_cnt_reg <= pc_same ? same_cnt_reg + 1'b1 : '0;
                if (hang_hit) hang_reg <= 1'b1;
            end
        end
    end

    assign cpu_reset   = (state_reg != ST_RUN);
    assign state       = state_reg;
    assign rd_valid    = rd_valid_reg;
    assign rd_pc       = rd_pc_reg;
    assign rd_result   = rd_result_reg;
    assign trace_count = count_reg;
    assign overflow    = overflow_reg;
    assign hang        = hang_reg;
    assign cycle_count = cycle_count_reg;
endmodule
